// File: rtl/downcounter_timer_pkg.sv
// ---------------------------------------------------------------------------
// downcounter_timer_pkg
//   Shared definitions for the downcounter_timer block.
//   - state_t   : timer FSM state (IDLE, RUN, DONE), 2-bit encoding
//   - W_DEFAULT : default counter / load-value width
// ---------------------------------------------------------------------------
package downcounter_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int W_DEFAULT = 3;

endpackage : downcounter_timer_pkg

// File: rtl/downcounter_timer_step.sv
// ---------------------------------------------------------------------------
// downcounter_timer_step
//   Purely combinational decrement with terminal detect for the timer
//   datapath.
//   Ports:
//     cnt_i    : current counter value
//     dec_o    : cnt_i - 1 (only meaningful when cnt_i != 0)
//     is_one_o : cnt_i == 1, i.e. the next tick is the terminal tick
//     is_zero_o: cnt_i == 0
// ---------------------------------------------------------------------------
module downcounter_timer_step #(
   parameter int W = 3
) (
   input  logic [W-1:0] cnt_i,
   output logic [W-1:0] dec_o,
   output logic         is_one_o,
   output logic         is_zero_o
);

   assign dec_o     = cnt_i - W'(1);
   assign is_one_o  = (cnt_i == W'(1));
   assign is_zero_o = (cnt_i == '0);

endmodule : downcounter_timer_step

// File: rtl/downcounter_timer.sv
// ---------------------------------------------------------------------------
// downcounter_timer
//   Loadable down counter used as an interval timer. Counts one step per
//   en tick while running, pulses tc for one cycle at terminal count, and
//   either stops (one-shot) or reloads (periodic).
//   Ports:
//     clk, rst  : clock (rising edge), synchronous active-high reset
//     load      : capture load_val (count+reload when idle, reload only in RUN)
//     load_val  : W-bit load value
//     start     : enter RUN if the (post-load) count is nonzero
//     stop      : abort RUN, count holds
//     periodic  : mode, sampled at start (1 = auto-reload, 0 = one-shot)
//     en        : count tick qualifier, only honoured in RUN
//     count     : current counter value (registered)
//     busy      : high in RUN
//     tc        : one-cycle terminal-count pulse (registered)
//     done      : one-shot completion level (DONE state)
//   Priority within a cycle: rst > stop > load > start > en tick.
// ---------------------------------------------------------------------------
module downcounter_timer
   import downcounter_timer_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         tc,
   output logic         done
);

   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] reload_q, reload_d;
   logic         mode_q, mode_d;
   logic         tc_q, tc_d;

   logic [W-1:0] count_dec;
   logic         count_is_one;
   logic         count_is_zero;
   logic         start_ok;

   downcounter_timer_step #(.W(W)) u_step (
      .cnt_i     (count_q),
      .dec_o     (count_dec),
      .is_one_o  (count_is_one),
      .is_zero_o (count_is_zero)
   );

   // start evaluates against the value load is about to write when both
   // arrive together outside RUN.
   assign start_ok = load ? (load_val != '0) : !count_is_zero;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;

      if (state_q == ST_RUN && stop) begin
         // stop beats a simultaneous terminal tick: no tc, count holds.
         state_d = ST_IDLE;
      end else begin
         if (load) begin
            reload_d = load_val;
            if (state_q != ST_RUN) begin
               count_d = load_val;
               state_d = ST_IDLE;
            end
         end

         if (start && state_q != ST_RUN && start_ok) begin
            mode_d  = periodic;
            state_d = ST_RUN;
         end

         // A same-cycle load in RUN has already updated reload_d, so a
         // terminal tick in that cycle reloads the new value.
         if (state_q == ST_RUN && en && !count_is_zero) begin
            if (!count_is_one) begin
               count_d = count_dec;
            end else begin
               tc_d = 1'b1;
               if (mode_q && reload_d != '0) begin
                  count_d = reload_d;
               end else begin
                  count_d = '0;
                  state_d = ST_DONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         tc_q     <= tc_d;
      end
   end

   assign count = count_q;
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign tc    = tc_q;

endmodule : downcounter_timer

// File: tb/tb_downcounter_timer.sv
// ---------------------------------------------------------------------------
// tb_downcounter_timer
//   Directed scenarios followed by a randomized run; every cycle the DUT
//   outputs are compared against a behavioural timer model.
// ---------------------------------------------------------------------------
module tb_downcounter_timer;

   localparam int W = 3;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         periodic = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;
   logic         done;

   int checks = 0;
   int failures = 0;

   // behavioural model state
   int m_count = 0;
   int m_reload = 0;
   bit m_periodic = 0;
   bit m_running = 0;
   bit m_finished = 0;
   bit m_tc = 0;

   logic [W-1:0] exp_q[$];

   downcounter_timer #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .en       (en),
      .count    (count),
      .busy     (busy),
      .tc       (tc),
      .done     (done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model of one clock edge: what the timer does, expressed as the rules
   // of the block (abort, load, start, tick) in priority order.
   task automatic model_edge();
      bit was_running;
      if (rst) begin
         m_count = 0; m_reload = 0; m_periodic = 0;
         m_running = 0; m_finished = 0; m_tc = 0;
         return;
      end
      m_tc = 0;
      was_running = m_running;
      if (was_running && stop) begin
         m_running = 0;
         return;
      end
      if (load) begin
         m_reload = int'(load_val);
         if (!was_running) begin
            m_count = int'(load_val);
            m_finished = 0;
         end
      end
      if (start && !was_running && m_count != 0) begin
         m_periodic = periodic;
         m_running = 1;
         m_finished = 0;
      end
      if (was_running && en) begin
         if (m_count > 1) begin
            m_count = m_count - 1;
         end else begin
            m_tc = 1;
            if (m_periodic && m_reload != 0) begin
               m_count = m_reload;
            end else begin
               m_count = 0;
               m_running = 0;
               m_finished = 1;
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit r, input bit ld, input int lv, input bit st,
                        input bit sp, input bit per, input bit e);
      rst = r; load = ld; load_val = W'(lv); start = st;
      stop = sp; periodic = per; en = e;
   endtask

   // One clock: apply current inputs, update model, compare after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("count", 32'(count), 32'(m_count));
      check("busy", 32'(busy), 32'(m_running));
      check("tc", 32'(tc), 32'(m_tc));
      check("done", 32'(done), 32'(m_finished));
   endtask

   task automatic cyc(input bit r, input bit ld, input int lv, input bit st,
                      input bit sp, input bit per, input bit e);
      drive(r, ld, lv, st, sp, per, e);
      step();
   endtask

   initial begin
      // ---- reset with load/start asserted ----
      cyc(1, 1, 5, 1, 0, 0, 1);
      cyc(1, 1, 5, 1, 0, 0, 1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("rst_release_busy", 32'(busy), 32'd0);

      // ---- one-shot 5 ----
      cyc(0, 1, 5, 0, 0, 0, 0);
      exp_q = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      cyc(0, 0, 0, 1, 0, 0, 1);
      check("oneshot_seq", 32'(count), 32'(exp_q.pop_front()));
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         check("oneshot_seq", 32'(count), 32'(exp_q.pop_front()));
      end
      check("oneshot_tc", 32'(tc), 32'd1);
      check("oneshot_done", 32'(done), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("oneshot_tc_single", 32'(tc), 32'd0);

      // ---- start with count==0 is ignored ----
      cyc(0, 0, 0, 1, 0, 1, 1);
      check("start_zero_busy", 32'(busy), 32'd0);

      // ---- periodic 3 ----
      cyc(0, 1, 3, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 1);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 0);

      // ---- enable gaps ----
      cyc(0, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      begin
         bit gaps[7] = '{1, 0, 0, 1, 1, 0, 1};
         foreach (gaps[i]) cyc(0, 0, 0, 0, 0, 0, gaps[i]);
      end

      // ---- stop vs terminal tick ----
      cyc(0, 1, 2, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 1);
      check("stop_hold_count", 32'(count), 32'd1);
      check("stop_no_tc", 32'(tc), 32'd0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("resume_tc", 32'(tc), 32'd1);

      // ---- load during periodic RUN ----
      cyc(0, 1, 2, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
      cyc(0, 1, 7, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("reload_new", 32'(count), 32'd7);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1);

      // ---- load 0 during periodic RUN ends at DONE ----
      cyc(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1);

      // ---- periodic reload 1: tc every tick ----
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 0);

      // ---- reset mid-RUN at count 3 ----
      cyc(0, 1, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("pre_rst_count", 32'(count), 32'd3);
      cyc(1, 0, 0, 0, 0, 0, 1);
      check("midrun_rst_count", 32'(count), 32'd0);
      check("midrun_rst_tc", 32'(tc), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1);

      // ---- randomized ----
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 12),
               int'($urandom_range(0, MAXV)),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 4),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 70));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_downcounter_timer
